rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

RC4 pseudo-random generation and decrypt stage that runs directly downstream of the key-scheduling FSM. Once the scheduler has left a permuted S array in the shared `s_memory`, this block walks the PRGA loop and produces the keystream. It XORs each keystream byte with the encrypted message ROM and writes the plaintext to a result RAM. It checks every plaintext byte on the fly and reports `done` or `failed`, which the key-search controller uses to accept or reject the current candidate key.

## Interface
Parameters:
- `MSG_LEN`, default 32: number of message bytes (1..256).
- `MSG_AW`, default 5: address width of the message ROM and result RAM, with `2**MSG_AW >= MSG_LEN`.

Ports:
- `clk` in 1: the single clock. Everything is on the rising edge.
- `reset` in 1: synchronous, active-high. One clock; reset is synchronous and active-high.
- `start` in 1: one-cycle request to begin decryption. Sampled only in IDLE, DONE and FAIL.
- `s_address` out 8: S memory address.
- `s_data` out 8: S memory write data.
- `s_wren` out 1: S memory write enable.
- `s_q` in 8: S memory read data.
- `rom_address` out MSG_AW: encrypted-message ROM address.
- `rom_q` in 8: encrypted byte.
- `ram_address` out MSG_AW: result RAM address.
- `ram_data` out 8: plaintext byte.
- `ram_wren` out 1: result RAM write enable.
- `busy` out 1: high in every state except IDLE, DONE and FAIL.
- `done` out 1: level signal. All MSG_LEN bytes were valid.
- `failed` out 1: level signal. An invalid plaintext byte was found.

## Operation
- Registers:
  - `i` and `j` (8-bit, mod-256 wrap).
  - `k` (message index, MSG_AW+1 bits).
  - `si`, `sj` and `f` (8-bit).
- All memories have a synchronous read with one-cycle latency. The block drives an address in cycle t, spends one wait state, and samples `q` in cycle t+2.
- States, with 12 per-byte states:
  - IDLE → RD_I on `start`. `i`, `j` and `k` are cleared.
  - RD_I: `i <= i+1`; `s_address = i+1`; `rom_address = k`.
  - WT_I → CAP_I: `si <= s_q`; `j <= j + s_q`.
  - RD_J: `s_address = j` (the updated `j`).
  - WT_J → CAP_J: `sj <= s_q`.
  - WR_I: `s_address = i`, `s_data = sj`, `s_wren = 1`.
  - WR_J: `s_address = j`, `s_data = si`, `s_wren = 1`.
  - RD_F: `s_address = si + sj` (mod 256).
  - WT_F → CAP_F: `f <= s_q`.
  - WR_OUT: `ram_address = k`, `ram_data = f ^ rom_q`, `ram_wren = 1`.
- Transitions out of WR_OUT:
  - If the byte is invalid → FAIL.
  - Else if `k == MSG_LEN-1` → DONE.
  - Else `k <= k+1` → RD_I.
- A valid byte is 0x61..0x7A (a–z) or 0x20 (space).
- An invalid byte is still written to the RAM before FAIL.
- DONE and FAIL hold their flag. A `start` there clears both flags, clears `i`, `j` and `k`, and goes to RD_I.
- `start` while `busy` is ignored.
- `i == j`: both swap writes hit the same address. The result is unchanged and needs no special case.
- Write enables are high only in WR_I, WR_J and WR_OUT.
- Addresses are don't-care when their enable is low. They are held at 0 in IDLE, DONE and FAIL.

## Timing
- Reset values: every output is 0, the state is IDLE, and `i`, `j`, `k`, `si`, `sj` and `f` are 0.
- Reset mid-operation:
  - IDLE is reached on the next edge and all write enables drop at once.
  - Memory contents are not restored.
- Byte cost: exactly 12 cycles per byte.
- If `start` is sampled at edge 0:
  - RD_I occupies cycle 1.
  - The first WR_OUT is in cycle 12.
  - `done` goes high at edge 12·MSG_LEN+1, which is 385 for the default.
- A failure on byte n (0-based) raises `failed` at edge 12·(n+1)+1.
- `done` and `failed` are never high together. `busy` is low in the same cycle that either flag rises.

## Test plan
- Byte 0 happy path: identity S (S[x]=x), rom[0]=0x63, rom[1]=0x64, MSG_LEN=2, pulse `start`. Required response:
  - ram[0]=0x61 and ram[1]=0x61.
  - S[2]=0x03 and S[3]=0x02.
  - `done` high at edge 25, `failed` low.
- Space acceptance: identity S, rom[0]=0x22, MSG_LEN=1 → ram[0]=0x20 and `done` at edge 13.
- Early failure: identity S, rom[0]=0x00 → ram[0]=0x02 is written, `failed` at edge 13, and no further S writes occur.
- Full message: S produced by the key scheduler for key 0x000249 with the lab's encrypted ROM. Required response:
  - All 32 RAM bytes match the golden plaintext.
  - `done` at edge 385.
  - Wrong key 0x000248 → `failed` is asserted.
- Control: pulse `reset` in WT_J of byte 5. Required response:
  - All outputs are 0 on the next cycle.
  - A new `start` restarts from `k=0`.
  - A `start` while busy causes no change.
  - A `start` in DONE clears `done` and reruns.
- Wrap: S preset so that `i` and `j` and `si+sj` overflow 255 → addresses wrap mod 256, checked against the C reference model byte for byte.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA + decrypt stage: walks the keystream loop over a pre-permuted S
// array, XORs each keystream byte with the encrypted ROM, writes plaintext
// to the result RAM and flags done/failed based on a lowercase+space check.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              failed
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_I, S_WT_I, S_CAP_I,
        S_RD_J, S_WT_J, S_CAP_J,
        S_WR_I, S_WR_J,
        S_RD_F, S_WT_F, S_CAP_F,
        S_WR_OUT,
        S_DONE, S_FAIL
    } state_t;

    localparam logic [MSG_AW:0] LAST_K = (MSG_AW + 1)'(MSG_LEN - 1);
    localparam logic [MSG_AW:0] K_ONE  = (MSG_AW + 1)'(1);

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [7:0]      i_q, i_d;
    logic [7:0]      j_q, j_d;
    logic [MSG_AW:0] k_q, k_d;
    logic [7:0]      si_q, si_d;
    logic [7:0]      sj_q, sj_d;
    logic [7:0]      f_q, f_d;

    logic            idle_like;
    logic [7:0]      pt_byte;
    logic            pt_valid;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
    assign pt_byte   = f_q ^ rom_q;
    assign pt_valid  = (pt_byte == 8'h20) || ((pt_byte >= 8'h61) && (pt_byte <= 8'h7a));

    // State and datapath registers; synchronous reset returns everything to IDLE/zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            f_q     <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            f_q     <= f_d;
        end
    end

    // Next-state, datapath updates and memory-port drive for the 12-state byte loop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        si_d        = si_q;
        sj_d        = sj_q;
        f_d         = f_q;
        s_address   = 8'h00;
        s_data      = 8'h00;
        s_wren      = 1'b0;
        rom_address = '0;
        ram_address = '0;
        ram_data    = 8'h00;
        ram_wren    = 1'b0;

        // A request is registered once and only while waiting, so a start
        // seen during the loop (or on its last cycle) never leaks through.
        start_d = start && idle_like;

        // The message index stays on both byte ports for the whole loop, so
        // rom_q has long settled when WR_OUT consumes it.
        if (!idle_like) begin
            rom_address = k_q[MSG_AW-1:0];
            ram_address = k_q[MSG_AW-1:0];
        end

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_q) begin
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_RD_I;
                end
            end
            S_RD_I: begin
                i_d       = i_q + 8'd1;
                s_address = i_q + 8'd1;
                state_d   = S_WT_I;
            end
            // Wait states keep the read address stable so q is still valid
            // two cycles after it was first presented.
            S_WT_I: begin
                s_address = i_q;
                state_d   = S_CAP_I;
            end
            S_CAP_I: begin
                s_address = i_q;
                si_d      = s_q;
                j_d       = j_q + s_q;
                state_d   = S_RD_J;
            end
            S_RD_J: begin
                s_address = j_q;
                state_d   = S_WT_J;
            end
            S_WT_J: begin
                s_address = j_q;
                state_d   = S_CAP_J;
            end
            S_CAP_J: begin
                s_address = j_q;
                sj_d      = s_q;
                state_d   = S_WR_I;
            end
            // When i == j both writes land on one address and the second
            // simply rewrites the original value, which is the correct swap.
            S_WR_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
                state_d   = S_WR_J;
            end
            S_WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
                state_d   = S_RD_F;
            end
            S_RD_F: begin
                s_address = si_q + sj_q;
                state_d   = S_WT_F;
            end
            S_WT_F: begin
                s_address = si_q + sj_q;
                state_d   = S_CAP_F;
            end
            S_CAP_F: begin
                s_address = si_q + sj_q;
                f_d       = s_q;
                state_d   = S_WR_OUT;
            end
            // The plaintext byte is always written, even when it rejects the key.
            S_WR_OUT: begin
                ram_data = pt_byte;
                ram_wren = 1'b1;
                if (!pt_valid) begin
                    state_d = S_FAIL;
                end else if (k_q == LAST_K) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + K_ONE;
                    state_d = S_RD_I;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy   = !idle_like;
    assign done   = (state_q == S_DONE);
    assign failed = (state_q == S_FAIL);

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: four instances (MSG_LEN 1, 2, 32, 256) share
// behavioural S/ROM/RAM models through a select mux. Expected RAM writes are
// queued when a run is set up; a negedge monitor pops and compares them.
module tb_rc4_prga_decrypt;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       load_req;
    logic [1:0] sel;

    always #5 clk = ~clk;

    // Per-instance outputs, widened to 8-bit addresses.
    logic [7:0] s_addr_v   [4];
    logic [7:0] s_data_v   [4];
    logic       s_wren_v   [4];
    logic [7:0] rom_addr_v [4];
    logic [7:0] ram_addr_v [4];
    logic [7:0] ram_data_v [4];
    logic       ram_wren_v [4];
    logic       busy_v     [4];
    logic       done_v     [4];
    logic       failed_v   [4];

    logic [7:0] s_q;
    logic [7:0] rom_q;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 32 : 256;
        localparam int AW = (g == 0) ? 1 : (g == 1) ? 1 : (g == 2) ? 5 : 8;
        logic [AW-1:0] rom_a;
        logic [AW-1:0] ram_a;
        rc4_prga_decrypt #(.MSG_LEN(L), .MSG_AW(AW)) u_dut (
            .clk         (clk),
            .reset       (reset),
            .start       (start && (sel == 2'(g))),
            .s_address   (s_addr_v[g]),
            .s_data      (s_data_v[g]),
            .s_wren      (s_wren_v[g]),
            .s_q         (s_q),
            .rom_address (rom_a),
            .rom_q       (rom_q),
            .ram_address (ram_a),
            .ram_data    (ram_data_v[g]),
            .ram_wren    (ram_wren_v[g]),
            .busy        (busy_v[g]),
            .done        (done_v[g]),
            .failed      (failed_v[g])
        );
        assign rom_addr_v[g] = 8'(rom_a);
        assign ram_addr_v[g] = 8'(ram_a);
    end

    // Selected instance.
    logic [7:0] m_s_address, m_s_data, m_rom_address, m_ram_address, m_ram_data;
    logic       m_s_wren, m_ram_wren, m_busy, m_done, m_failed;
    assign m_s_address   = s_addr_v[sel];
    assign m_s_data      = s_data_v[sel];
    assign m_s_wren      = s_wren_v[sel];
    assign m_rom_address = rom_addr_v[sel];
    assign m_ram_address = ram_addr_v[sel];
    assign m_ram_data    = ram_data_v[sel];
    assign m_ram_wren    = ram_wren_v[sel];
    assign m_busy        = busy_v[sel];
    assign m_done        = done_v[sel];
    assign m_failed      = failed_v[sel];

    // Memories: environment copies plus the reference model's own S.
    logic [7:0] s_mem   [256];
    logic [7:0] s_init  [256];
    logic [7:0] m_s     [256];
    logic [7:0] rom_mem [256];
    logic [7:0] ram_mem [256];

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
        end else if (m_s_wren) begin
            s_mem[m_s_address] <= m_s_data;
        end
        s_q   <= s_mem[m_s_address];
        rom_q <= rom_mem[m_rom_address];
        if (m_ram_wren) ram_mem[m_ram_address] <= m_ram_data;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          s_wr_cnt = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: count S writes and score every result-RAM write.
    always @(negedge clk) begin
        logic [15:0] e;
        if (m_s_wren) s_wr_cnt <= s_wr_cnt + 1;
        if (m_ram_wren) begin
            if (sb_q.size() == 0) begin
                check("ram_unexpected_write", {m_ram_address, m_ram_data}, 64'hdead);
            end else begin
                e = sb_q.pop_front();
                check("ram_addr", m_ram_address, e[15:8]);
                check("ram_data", m_ram_data, e[7:0]);
            end
        end
    end

    string msg_txt = "attack at dawn with the red fox ";

    function automatic logic [7:0] txt_byte(input int k);
        return msg_txt[k % 32];
    endfunction

    function automatic bit is_valid(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7a));
    endfunction

    // C-style reference PRGA on m_s. gen=1 builds the ROM from the text;
    // gen=0 queues the expected RAM writes up to and including the first bad byte.
    task automatic model_run(input int len, input int max_bytes, input bit gen,
                             output int n_bytes, output bit ok_all);
        logic [7:0] i, j, si, sj, f, a, pt;
        i = 8'd0; j = 8'd0; n_bytes = 0; ok_all = 1'b1;
        for (int k = 0; k < len && k < max_bytes; k++) begin
            i = i + 8'd1;
            si = m_s[i];
            j = j + si;
            sj = m_s[j];
            m_s[i] = sj;
            m_s[j] = si;
            a = si + sj;
            f = m_s[a];
            if (gen) rom_mem[k] = txt_byte(k) ^ f;
            pt = f ^ rom_mem[k];
            n_bytes++;
            if (!gen) sb_q.push_back({8'(k), pt});
            if (!is_valid(pt)) begin
                ok_all = 1'b0;
                break;
            end
        end
    endtask

    task automatic ksa(input logic [23:0] key);
        logic [7:0] j, t, kb;
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        j = 8'd0;
        for (int a = 0; a < 256; a++) begin
            kb = (a % 3 == 0) ? key[23:16] : (a % 3 == 1) ? key[15:8] : key[7:0];
            j = j + s_init[a] + kb;
            t = s_init[a];
            s_init[a] = s_init[j];
            s_init[j] = t;
        end
    endtask

    task automatic identity_s();
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
    endtask

    task automatic load_s_mem();
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    // Pulse start (sampled at edge 0), then count edges until done/failed.
    task automatic run_dut(input int exp_edge, input bit exp_done, input int exp_swr,
                           input int poke_at, input string tag);
        int n;
        int base;
        bit hit;
        base = s_wr_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < exp_edge + 40) begin
            if (n == poke_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n++;
            if (n == 1) check({tag, "_edge1_busy_done_failed"}, {m_busy, m_done, m_failed}, 3'b100);
            if (m_done || m_failed) hit = 1'b1;
        end
        check({tag, "_flag_edge"}, n, exp_edge);
        check({tag, "_flags"}, {m_done, m_failed, m_busy}, {exp_done, !exp_done, 1'b0});
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_flags_hold"}, {m_done, m_failed, m_busy}, {exp_done, !exp_done, 1'b0});
        check({tag, "_s_writes"}, s_wr_cnt - base, exp_swr);
        check({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        int nb;
        bit ok;
        int base;
        reset = 1'b1;
        start = 1'b0;
        load_req = 1'b0;
        sel = 2'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int g = 0; g < 4; g++) begin
            sel = 2'(g);
            #1;
            check("reset_outputs",
                  {m_s_address, m_s_data, m_s_wren, m_rom_address, m_ram_address,
                   m_ram_data, m_ram_wren, m_busy, m_done, m_failed}, 64'd0);
        end

        // Byte-0 happy path, MSG_LEN=2.
        sel = 2'd1;
        identity_s();
        rom_mem[0] = 8'h63;
        rom_mem[1] = 8'h64;
        load_s_mem();
        sb_q.push_back({8'h00, 8'h61});
        sb_q.push_back({8'h01, 8'h61});
        run_dut(25, 1'b1, 4, -1, "happy");
        check("happy_S2", s_mem[2], 8'h03);
        check("happy_S3", s_mem[3], 8'h02);

        // Space acceptance, MSG_LEN=1.
        sel = 2'd0;
        identity_s();
        rom_mem[0] = 8'h22;
        load_s_mem();
        sb_q.push_back({8'h00, 8'h20});
        run_dut(13, 1'b1, 2, -1, "space");

        // Early failure on byte 0.
        sel = 2'd1;
        identity_s();
        rom_mem[0] = 8'h00;
        load_s_mem();
        sb_q.push_back({8'h00, 8'h02});
        run_dut(13, 1'b0, 2, -1, "early_fail");
        check("early_fail_ram0", ram_mem[0], 8'h02);

        // Key 0x000249: build the ROM from the known text.
        sel = 2'd2;
        ksa(24'h000249);
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        model_run(32, 32, 1'b1, nb, ok);

        // Reset during WT_J of byte 5.
        load_s_mem();
        model_run(32, 5, 1'b0, nb, ok);
        base = s_wr_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (65) @(posedge clk);
        #1;
        check("rst_mid_busy", m_busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mid_outputs",
              {m_s_address, m_s_data, m_s_wren, m_rom_address, m_ram_address,
               m_ram_data, m_ram_wren, m_busy, m_done, m_failed}, 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_s_writes", s_wr_cnt - base, 10);
        check("rst_mid_sb_empty", sb_q.size(), 0);

        // Full message from k=0, with a start poked while busy.
        load_s_mem();
        for (int k = 0; k < 32; k++) sb_q.push_back({8'(k), txt_byte(k)});
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        model_run(32, 32, 1'b1, nb, ok);
        run_dut(385, 1'b1, 64, 100, "full");
        for (int k = 0; k < 32; k++) check("full_ram_byte", ram_mem[k], txt_byte(k));

        // Start from DONE reruns on the now-modified S.
        model_run(32, 32, 1'b0, nb, ok);
        run_dut(12 * nb + 1, ok, 2 * nb, -1, "rerun");

        // Wrong key rejects.
        ksa(24'h000248);
        load_s_mem();
        model_run(32, 32, 1'b0, nb, ok);
        run_dut(12 * nb + 1, ok, 2 * nb, -1, "wrong_key");
        check("wrong_key_failed", m_failed, 1'b1);

        // Wrap: reversed S, 256 bytes so i, j and si+sj all wrap.
        sel = 2'd3;
        for (int a = 0; a < 256; a++) s_init[a] = 8'(255 - a);
        for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
        model_run(256, 256, 1'b1, nb, ok);
        load_s_mem();
        model_run(256, 256, 1'b0, nb, ok);
        run_dut(3073, 1'b1, 512, -1, "wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
